gate_selftest_ctrl: RTL and testbench

GATE_SELFTEST_CTRL -- requirements
Module: gate_selftest_ctrl

---
 rtl/gate_selftest_ctrl.sv | 134 +++++++++++++
 tb/tb_gate_selftest_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer for an 8-gate block: sweeps {a,b}, checks the
// returned gate results and accumulates a sticky fail mask and error count.
`timescale 1ns/1ps

module gate_selftest_ctrl #(
    parameter int NUM_PASSES = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk_in,
    input  logic             rstn_in,
    input  logic             start_in,
    input  logic             abort_in,
    output logic             a_out,
    output logic             b_out,
    input  logic [7:0]       res_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             pass_out,
    output logic [7:0]       fail_mask_out,
    output logic [ERR_W-1:0] err_cnt_out
);

    localparam int NUM_VEC = 4 * NUM_PASSES;
    localparam int IDX_W   = $clog2(NUM_VEC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic             go;
    logic             last_vec;
    logic             do_cmp;
    logic [7:0]       exp_res;
    logic [7:0]       mism;
    logic             cnt_full;

    assign idx_inc  = idx + IDX_W'(1);
    assign last_vec = (idx == LAST_IDX);
    assign go       = ((state == S_IDLE) || (state == S_DONE))
                      && start_in && !abort_in;
    assign do_cmp   = (state == S_SAMPLE) && !abort_in;
    assign cnt_full = &err_cnt_out;

    // Bit order: not, buf, and, or, nand, nor, xor, xnor (LSB first)
    assign exp_res = {
        ~(a_out ^ b_out),
        a_out ^ b_out,
        ~(a_out | b_out),
        ~(a_out & b_out),
        a_out | b_out,
        a_out & b_out,
        a_out,
        ~a_out
    };
    assign mism = res_in ^ exp_res;

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort_in) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (start_in) state_nxt = S_APPLY;
                S_APPLY:  state_nxt = S_SAMPLE;
                S_SAMPLE: state_nxt = last_vec ? S_DONE : S_APPLY;
                S_DONE:   if (start_in) state_nxt = S_APPLY;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_out = 1'b0;
        done_out = 1'b0;
        pass_out = 1'b0;
        unique case (state)
            S_APPLY:  busy_out = 1'b1;
            S_SAMPLE: busy_out = 1'b1;
            S_DONE: begin
                done_out = 1'b1;
                pass_out = (fail_mask_out == 8'h00);
            end
            default: ;
        endcase
    end

    // Abort keeps the accumulated results but parks the stimulus at 00
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            idx           <= '0;
            a_out         <= 1'b0;
            b_out         <= 1'b0;
            fail_mask_out <= 8'h00;
            err_cnt_out   <= '0;
        end else if (abort_in) begin
            idx   <= '0;
            a_out <= 1'b0;
            b_out <= 1'b0;
        end else if (go) begin
            idx           <= '0;
            a_out         <= 1'b0;
            b_out         <= 1'b0;
            fail_mask_out <= 8'h00;
            err_cnt_out   <= '0;
        end else if (do_cmp) begin
            fail_mask_out <= fail_mask_out | mism;
            if ((|mism) && !cnt_full) begin
                err_cnt_out <= err_cnt_out + ERR_W'(1);
            end
            if (!last_vec) begin
                idx   <= idx_inc;
                a_out <= idx_inc[1];
                b_out <= idx_inc[0];
            end
        end
    end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Scoreboard bench for gate_selftest_ctrl: randomized fault-injected runs,
// aborts, ignored starts and mid-run resets against a run-level model.
`timescale 1ns/1ps

module tb_gate_selftest_ctrl;

    localparam int NP = 4;
    localparam int NV = 4 * NP;
    localparam int NE = 8 * NP;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       a, b, busy, done, pass;
    logic [7:0] mask;
    logic [7:0] cnt;
    logic       a2, b2, busy2, done2, pass2;
    logic [7:0] mask2;
    logic [1:0] cnt2;
    logic [7:0] res;
    logic [7:0] flip = 8'h00;
    logic [7:0] s0 = 8'h00;
    logic [7:0] s1 = 8'h00;

    always #5 clk = ~clk;

    gate_selftest_ctrl #(.NUM_PASSES(NP), .ERR_W(8)) u_dut (
        .clk_in(clk), .rstn_in(rstn), .start_in(start), .abort_in(abort),
        .a_out(a), .b_out(b), .res_in(res), .busy_out(busy),
        .done_out(done), .pass_out(pass), .fail_mask_out(mask),
        .err_cnt_out(cnt)
    );

    gate_selftest_ctrl #(.NUM_PASSES(NP), .ERR_W(2)) u_sat (
        .clk_in(clk), .rstn_in(rstn), .start_in(start), .abort_in(abort),
        .a_out(a2), .b_out(b2), .res_in(res), .busy_out(busy2),
        .done_out(done2), .pass_out(pass2), .fail_mask_out(mask2),
        .err_cnt_out(cnt2)
    );

    function automatic logic gate(input int g, input logic x, input logic y);
        case (g)
            0: return !x;
            1: return x;
            2: return x && y;
            3: return x || y;
            4: return !(x && y);
            5: return !(x || y);
            6: return x != y;
            default: return x == y;
        endcase
    endfunction

    function automatic logic [7:0] golden(input logic x, input logic y);
        logic [7:0] r;
        r = 8'h00;
        for (int g = 0; g < 8; g++) r[g] = gate(g, x, y);
        return r;
    endfunction

    // Gate block under test with programmable faults
    always_comb res = ((golden(a, b) ^ flip) | s1) & ~s0;

    typedef struct {
        int         cycles;
        bit         fin;
        logic [7:0] mask;
        int         cnt;
    } rec_t;

    rec_t exp_q[$];
    rec_t last;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic rec_t predict(input logic [7:0] f, input logic [7:0] z,
                                     input logic [7:0] o, input int nvec,
                                     input int cycles, input bit fin);
        rec_t r;
        logic [7:0] g, fa, d;
        r.mask = 8'h00;
        r.cnt = 0;
        for (int k = 0; k < nvec; k++) begin
            g = golden(((k >> 1) & 1) == 1, (k & 1) == 1);
            fa = ((g ^ f) | o) & ~z;
            d = g ^ fa;
            r.mask |= d;
            if (d != 8'h00) r.cnt++;
        end
        r.cycles = cycles;
        r.fin = fin;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: sweep order while busy, results when busy falls, hold after
    initial begin : monitor
        int bc;
        bit pb;
        rec_t r;
        bc = 0;
        pb = 1'b0;
        last = '{0, 1'b0, 8'h00, 0};
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("reset_outputs", {a, b, busy, done, pass, mask, cnt},
                    64'd0);
                chk("reset_sat", {mask2, cnt2, pass2}, 64'd0);
                if (pb && exp_q.size() > 0) void'(exp_q.pop_front());
                last = '{0, 1'b0, 8'h00, 0};
                bc = 0;
                pb = 1'b0;
            end else begin
                if (busy) begin
                    chk("ab_sweep", {a, b}, (bc / 2) % 4);
                    chk("flags_busy", {done, pass}, 64'd0);
                    bc++;
                end else if (pb) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_end", 64'd1, 64'd0);
                    end else begin
                        r = exp_q.pop_front();
                        chk("run_edges", bc, r.cycles);
                        chk("done", done, r.fin);
                        chk("pass", pass, r.fin && (r.mask == 8'h00));
                        chk("fail_mask", mask, r.mask);
                        chk("err_cnt", cnt, sat(r.cnt, 255));
                        chk("err_cnt_sat", cnt2, sat(r.cnt, 3));
                        chk("fail_mask_sat", mask2, r.mask);
                        if (!r.fin) chk("ab_abort", {a, b}, 64'd0);
                        last = r;
                    end
                    bc = 0;
                end else begin
                    chk("held_mask", mask, last.mask);
                    chk("held_cnt", cnt, sat(last.cnt, 255));
                    chk("pass_idle", pass,
                        done ? (last.fin && last.mask == 8'h00) : 1'b0);
                end
                pb = busy;
            end
        end
    end

    task automatic run(input logic [7:0] f, input logic [7:0] z,
                       input logic [7:0] o, input int abort_e,
                       input bit ab_start, input int ghost_e, input int hold);
        int nv, cyc;
        bit fin;
        flip = f;
        s0 = z;
        s1 = o;
        if (abort_e > 0) begin
            nv = (abort_e - 1) / 2;
            cyc = abort_e;
            fin = 1'b0;
        end else begin
            nv = NV;
            cyc = NE;
            fin = 1'b1;
        end
        exp_q.push_back(predict(f, z, o, nv, cyc, fin));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int e = 1; e <= cyc; e++) begin
            if (e == ghost_e) start = 1'b1;
            if (e == abort_e) begin
                abort = 1'b1;
                if (ab_start) start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
        end
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic abort_idle(input bit with_start);
        abort = 1'b1;
        start = with_start;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid(input int k);
        exp_q.push_back('{0, 1'b0, 8'h00, 0});
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (k) @(posedge clk);
        #2 rstn = 1'b0;
        @(posedge clk);
        #3 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [7:0] f, z, o;
        int ae, gh;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run(8'h00, 8'h00, 8'h00, 0, 1'b0, 0, 3);
        run(8'h40, 8'h00, 8'h00, 0, 1'b0, 0, 2);
        run(8'h00, 8'h04, 8'h00, 0, 1'b0, 0, 2);
        abort_idle(1'b1);
        run(8'h81, 8'h00, 8'h00, 10, 1'b1, 0, 2);
        run(8'h00, 8'h00, 8'h00, 0, 1'b0, 8, 2);
        reset_mid(13);
        run(8'h00, 8'h00, 8'h00, 0, 1'b0, 0, 2);
        for (int i = 0; i < 24; i++) begin
            f = ($urandom_range(0, 1) == 0) ? 8'h00 :
                ($urandom_range(0, 1) == 0) ? 8'(1 << $urandom_range(0, 7)) :
                8'($urandom);
            z = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            o = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ae = ($urandom_range(0, 2) == 0) ? $urandom_range(1, NE - 1) : 0;
            gh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NE - 1) : 0;
            run(f, z, o, ae, 1'($urandom_range(0, 1)), gh,
                $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) abort_idle(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) reset_mid($urandom_range(1, NE - 2));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: run did not complete (compared %0d)", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
